sram_controller: RTL and testbench



---
 rtl/sram_ctrl_pkg.sv | 17 +
 rtl/sram_wait_counter.sv | 29 ++
 rtl/sram_controller.sv | 175 +++++++++++++++++
 tb/tb_sram_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared constants and state encoding for the 16-bit async SRAM controller.
package sram_ctrl_pkg;

    localparam int unsigned SRAM_ADDR_W       = 18;
    localparam int unsigned SRAM_DATA_W       = 16;
    localparam int unsigned WORD_IDX_W        = 17;
    localparam int unsigned CNT_W             = 4;
    localparam int unsigned SRAM_WAIT_DEFAULT = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOW  = 2'd1;
    localparam state_t ST_HIGH = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-half wait-state counter; tc_c flags the final cycle of a half access.
module sram_wait_counter
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned SRAM_WAIT = SRAM_WAIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc_c
);

    logic [CNT_W-1:0] count_q;

    // Clear has priority so the count restarts at zero for each half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign tc_c = (count_q == CNT_W'(SRAM_WAIT - 1));

endmodule

// File: rtl/sram_controller.sv
// 32-bit word access to a 16-bit async SRAM as two half accesses (low, then high).
// Optional one-entry read buffer enabled by SRAM_CTRL_READ_BUFFER_EN.
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter int unsigned SRAM_WAIT = SRAM_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);

    state_t                  state_q, state_d;
    logic                    op_wr_q, op_wr_d;
    logic [WORD_IDX_W-1:0]   word_q, word_d;
    logic [31:0]             data_q, data_d;
    logic [SRAM_ADDR_W-1:0]  addr_d;
    logic [SRAM_DATA_W-1:0]  dq_out_d;
    logic                    oe_d;
    logic                    we_n_d;
    logic [31:0]             rdata_d;

    logic                    req_c;
    logic [WORD_IDX_W-1:0]   word_c;
    logic                    tc_c;
    logic                    cnt_en_c;
    logic                    cnt_clear_c;
    logic                    buf_hit_c;
    logic [31:0]             buf_data_c;

    assign req_c  = rd_en | wr_en;
    assign word_c = WORD_IDX_W'((address - BASE_ADDR) >> 2);
    assign ready  = ~req_c | (state_q == ST_DONE);

    assign cnt_en_c    = (state_q == ST_LOW) | (state_q == ST_HIGH);
    assign cnt_clear_c = ~cnt_en_c | tc_c;

    sram_wait_counter #(
        .SRAM_WAIT (SRAM_WAIT)
    ) u_wait_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear_c),
        .enable (cnt_en_c),
        .tc_c   (tc_c)
    );

`ifdef SRAM_CTRL_READ_BUFFER_EN
    logic                  buf_valid_q;
    logic [WORD_IDX_W-1:0] buf_word_q;
    logic [31:0]           buf_data_q;

    assign buf_hit_c  = buf_valid_q & (buf_word_q == word_c);
    assign buf_data_c = buf_data_q;

    // Fill on read completion; keep coherent with writes that complete to the same word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_word_q  <= '0;
            buf_data_q  <= '0;
        end else if ((state_q == ST_HIGH) && tc_c) begin
            if (!op_wr_q) begin
                buf_valid_q <= 1'b1;
                buf_word_q  <= word_q;
                buf_data_q  <= {sram_dq_in, read_data[15:0]};
            end else if (buf_valid_q && (buf_word_q == word_q)) begin
                buf_data_q  <= data_q;
            end
        end
    end
`else
    assign buf_hit_c  = 1'b0;
    assign buf_data_c = '0;
`endif

    // State and registered SRAM/CPU-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_wr_q     <= 1'b0;
            word_q      <= '0;
            data_q      <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            read_data   <= '0;
        end else begin
            state_q     <= state_d;
            op_wr_q     <= op_wr_d;
            word_q      <= word_d;
            data_q      <= data_d;
            sram_addr   <= addr_d;
            sram_dq_out <= dq_out_d;
            sram_dq_oe  <= oe_d;
            sram_we_n   <= we_n_d;
            read_data   <= rdata_d;
        end
    end

    // Next state; SRAM pins are set up on the edge entering each half so they are
    // stable for the whole half access.
    always_comb begin
        state_d  = state_q;
        op_wr_d  = op_wr_q;
        word_d   = word_q;
        data_d   = data_q;
        addr_d   = sram_addr;
        dq_out_d = sram_dq_out;
        oe_d     = sram_dq_oe;
        we_n_d   = sram_we_n;
        rdata_d  = read_data;

        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    op_wr_d = wr_en;
                    word_d  = word_c;
                    data_d  = write_data;
                    if (!wr_en && buf_hit_c) begin
                        state_d = ST_DONE;
                        rdata_d = buf_data_c;
                    end else begin
                        state_d  = ST_LOW;
                        addr_d   = {word_c, 1'b0};
                        dq_out_d = write_data[15:0];
                        oe_d     = wr_en;
                        we_n_d   = ~wr_en;
                    end
                end
            end
            ST_LOW: begin
                if (tc_c) begin
                    state_d  = ST_HIGH;
                    addr_d   = {word_q, 1'b1};
                    dq_out_d = data_q[31:16];
                    if (!op_wr_q) begin
                        rdata_d[15:0] = sram_dq_in;
                    end
                end
            end
            ST_HIGH: begin
                if (tc_c) begin
                    state_d = ST_DONE;
                    oe_d    = 1'b0;
                    we_n_d  = 1'b1;
                    if (!op_wr_q) begin
                        rdata_d[31:16] = sram_dq_in;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                oe_d    = 1'b0;
                we_n_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural async SRAM model.
// Build with SRAM_CTRL_READ_BUFFER_EN defined to exercise the read buffer.
module tb_sram_controller;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    int checks = 0;
    int errors = 0;

`ifdef SRAM_CTRL_READ_BUFFER_EN
    localparam int HIT_LOW = 1;
`else
    localparam int HIT_LOW = 5;
`endif
    localparam int FULL_LOW = 5;

    sram_controller dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: 256 half-words, async read, write sampled on the clock edge.
    logic [15:0] mem [256];
    assign sram_dq_in = mem[sram_addr[7:0]];

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) begin
            mem[sram_addr[7:0]] <= sram_dq_out;
        end
    end

    logic [17:0] tr_addr [16];
    logic [15:0] tr_dq   [16];
    logic        tr_we_n [16];
    logic        tr_oe   [16];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        hit;
        logic [17:0] exp_addr0;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request and hold it until ready; trace SRAM pins per low cycle.
    task automatic run_req(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, output int low, output logic [31:0] rdata);
        bit done;
        low  = 0;
        done = 1'b0;
        @(negedge clk);
        rd_en      = rd;
        wr_en      = wr;
        address    = a;
        write_data = d;
        #1;
        for (int k = 0; k < 40 && !done; k++) begin
            if (ready) begin
                done = 1'b1;
            end else begin
                if (low < 16) begin
                    tr_addr[low] = sram_addr;
                    tr_dq[low]   = sram_dq_out;
                    tr_we_n[low] = sram_we_n;
                    tr_oe[low]   = sram_dq_oe;
                end
                low++;
                @(negedge clk);
                #1;
            end
        end
        rdata = read_data;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: ready still %b after 40 cycles, required 1", ready);
        end
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    int          low;
    logic [31:0] rdata;

    initial begin
        vecs[0] = '{rd:1'b1, wr:1'b0, addr:32'd1028, wdata:32'h0,        exp_rdata:32'hDEADBEEF, hit:1'b0, exp_addr0:18'h00002};
        vecs[1] = '{rd:1'b1, wr:1'b0, addr:32'd1028, wdata:32'h0,        exp_rdata:32'hDEADBEEF, hit:1'b1, exp_addr0:18'h00002};
        vecs[2] = '{rd:1'b1, wr:1'b1, addr:32'd1024, wdata:32'h12345678, exp_rdata:32'hDEADBEEF, hit:1'b0, exp_addr0:18'h00000};
        vecs[3] = '{rd:1'b0, wr:1'b1, addr:32'd1028, wdata:32'h00000000, exp_rdata:32'hDEADBEEF, hit:1'b0, exp_addr0:18'h00002};
        vecs[4] = '{rd:1'b1, wr:1'b0, addr:32'd1028, wdata:32'h0,        exp_rdata:32'h00000000, hit:1'b1, exp_addr0:18'h00002};
        vecs[5] = '{rd:1'b1, wr:1'b0, addr:32'd1024, wdata:32'h0,        exp_rdata:32'h12345678, hit:1'b0, exp_addr0:18'h00000};
        vecs[6] = '{rd:1'b1, wr:1'b0, addr:32'd1020, wdata:32'h0,        exp_rdata:32'h10FF10FE, hit:1'b0, exp_addr0:18'h3FFFE};

        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'(16'h1000 + i);
        end

        rst        = 1'b1;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = '0;
        write_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset / idle state.
        check("rst_ready",     32'(ready),      32'd1);
        check("rst_we_n",      32'(sram_we_n),  32'd1);
        check("rst_oe",        32'(sram_dq_oe), 32'd0);
        check("rst_read_data", read_data,       32'd0);
        check("rst_sram_addr", 32'(sram_addr),  32'd0);

        // Write 0xDEADBEEF to 1028: low half then high half, two cycles each.
        run_req(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, low, rdata);
        check("wr_low_cycles", 32'(low), 32'(FULL_LOW));
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("wr_addr_c%0d", c), 32'(tr_addr[c]), (c <= 2) ? 32'd2 : 32'd3);
            check($sformatf("wr_dq_c%0d", c),   32'(tr_dq[c]),   (c <= 2) ? 32'hBEEF : 32'hDEAD);
            check($sformatf("wr_we_n_c%0d", c), 32'(tr_we_n[c]), 32'd0);
            check($sformatf("wr_oe_c%0d", c),   32'(tr_oe[c]),   32'd1);
        end
        check("wr_done_we_n", 32'(sram_we_n),  32'd1);
        check("wr_done_oe",   32'(sram_dq_oe), 32'd0);
        check("wr_mem2", 32'(mem[2]), 32'hBEEF);
        check("wr_mem3", 32'(mem[3]), 32'hDEAD);
        check("wr_rdata_unchanged", rdata, 32'd0);

        // Table of reads/writes, including buffer hits and address wrap.
        for (int i = 0; i < 7; i++) begin
            int exp_low;
            exp_low = vecs[i].hit ? HIT_LOW : FULL_LOW;
            run_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, low, rdata);
            check($sformatf("v%0d_low_cycles", i), 32'(low), 32'(exp_low));
            check($sformatf("v%0d_read_data", i),  rdata,    vecs[i].exp_rdata);
            if (exp_low == FULL_LOW && low == FULL_LOW) begin
                check($sformatf("v%0d_addr_low", i),  32'(tr_addr[1]), 32'(vecs[i].exp_addr0));
                check($sformatf("v%0d_addr_high", i), 32'(tr_addr[3]), 32'(vecs[i].exp_addr0 | 18'd1));
                check($sformatf("v%0d_we_n", i),      32'(tr_we_n[1]), 32'(!vecs[i].wr));
            end
        end
        check("both_mem0", 32'(mem[0]), 32'h5678);
        check("both_mem1", 32'(mem[1]), 32'h1234);
        check("zero_mem2", 32'(mem[2]), 32'h0000);
        check("zero_mem3", 32'(mem[3]), 32'h0000);

        // Reset during the high half of a write to 1032 (SRAM words 4/5).
        @(negedge clk);
        wr_en      = 1'b1;
        address    = 32'd1032;
        write_data = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        #1;
        check("mid_high_addr", 32'(sram_addr), 32'd5);
        check("mid_high_we_n", 32'(sram_we_n), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_we_n", 32'(sram_we_n),   32'd1);
        check("mid_rst_oe",   32'(sram_dq_oe),  32'd0);
        check("mid_rst_addr", 32'(sram_addr),   32'd0);
        check("mid_rst_dq",   32'(sram_dq_out), 32'd0);
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ready),   32'd1);
        check("mid_rst_rdata", read_data,    32'd0);
        check("mid_rst_mem4",  32'(mem[4]),  32'hF00D);
        check("mid_rst_mem5",  32'(mem[5]),  32'h1005);

        // After reset the buffer is empty: a read of 1028 takes the full latency.
        run_req(1'b1, 1'b0, 32'd1028, 32'h0, low, rdata);
        check("post_rst_low_cycles", 32'(low), 32'(FULL_LOW));
        check("post_rst_read_data",  rdata,    32'h00000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
